// File: rtl/ball_engine.sv
// Pong ball physics and scoring engine: moves the ball once per frame tick,
// bounces it off walls and paddles, and keeps score. Optional macro: SPEEDUP_EN.
module ball_engine #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int BALL_SIZE    = 10,
  parameter int PADDLE_W     = 10,
  parameter int PADDLE_H     = 50,
  parameter int P1_X         = 0,
  parameter int P2_X         = 630,
  parameter int SPEED_X      = 2,
  parameter int SPEED_Y      = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 10,
  parameter int MAX_SPEED_X  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [8:0] p1_y,
  input  logic [8:0] p2_y,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       p1_point,
  output logic       p2_point,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SERVE = 2'b01,
    ST_PLAY  = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);
  localparam int SPD_W = $clog2(MAX_SPEED_X + 1);

  localparam logic [9:0]             L_CX       = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [8:0]             L_CY       = 9'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [CNT_W-1:0]       L_CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [3:0]             L_WIN      = 4'(WIN_SCORE);
  localparam logic signed [10:0]     L_SW       = 11'(SCREEN_W);
  localparam logic signed [10:0]     L_SH       = 11'(SCREEN_H);
  localparam logic signed [10:0]     L_BS       = 11'(BALL_SIZE);
  localparam logic signed [10:0]     L_PH       = 11'(PADDLE_H);
  localparam logic signed [10:0]     L_SPD_Y    = 11'(SPEED_Y);
  localparam logic signed [10:0]     L_P1_FACE  = 11'(P1_X + PADDLE_W);
  localparam logic signed [10:0]     L_P2_FACE  = 11'(P2_X);
  localparam logic signed [10:0]     L_P2_STOP  = 11'(P2_X - BALL_SIZE);
  localparam logic signed [10:0]     L_Y_MAX    = 11'(SCREEN_H - BALL_SIZE);

  state_t           r_state;
  logic [9:0]       r_ball_x;
  logic [8:0]       r_ball_y;
  logic [3:0]       r_p1_score;
  logic [3:0]       r_p2_score;
  logic             r_p1_point;
  logic             r_p2_point;
  logic             r_dx;      // 1 = moving right
  logic             r_dy;      // 1 = moving down
  logic [CNT_W-1:0] r_cnt;

  logic [SPD_W-1:0]   w_speed;
  logic signed [10:0] w_spd_x;
  logic signed [10:0] w_x_s;
  logic signed [10:0] w_y_s;
  logic signed [10:0] w_p1_s;
  logic signed [10:0] w_p2_s;
  logic signed [10:0] w_nx;
  logic signed [10:0] w_ny;
  logic               w_ov1;
  logic               w_ov2;
  logic [9:0]         w_next_x;
  logic [8:0]         w_next_y;
  logic               w_next_dx;
  logic               w_next_dy;
  logic               w_hit;
  logic               w_p1_scores;
  logic               w_p2_scores;
  logic [3:0]         w_p1_inc;
  logic [3:0]         w_p2_inc;
  logic               w_win;
  logic               w_tick_play;
  logic               w_enter_serve;

`ifdef SPEEDUP_EN
  logic [SPD_W-1:0] r_speed;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_speed <= SPD_W'(SPEED_X);
    end else if (w_enter_serve) begin
      r_speed <= SPD_W'(SPEED_X);
    end else if (w_tick_play && w_hit && (r_speed < SPD_W'(MAX_SPEED_X))) begin
      r_speed <= r_speed + 1'b1;
    end
  end

  assign w_speed = r_speed;
`else
  assign w_speed = SPD_W'(SPEED_X);
`endif

  assign w_spd_x = signed'(11'(w_speed));
  assign w_x_s   = signed'({1'b0, r_ball_x});
  assign w_y_s   = signed'({2'b0, r_ball_y});
  assign w_p1_s  = signed'({2'b0, p1_y});
  assign w_p2_s  = signed'({2'b0, p2_y});
  assign w_nx    = r_dx ? (w_x_s + w_spd_x) : (w_x_s - w_spd_x);
  assign w_ny    = r_dy ? (w_y_s + L_SPD_Y) : (w_y_s - L_SPD_Y);

  // Overlap is judged on the ball's position before this frame's move.
  assign w_ov1 = (w_y_s + L_BS > w_p1_s) && (w_y_s < w_p1_s + L_PH);
  assign w_ov2 = (w_y_s + L_BS > w_p2_s) && (w_y_s < w_p2_s + L_PH);

  always_comb begin
    w_next_y    = w_ny[8:0];
    w_next_dy   = r_dy;
    w_next_x    = w_nx[9:0];
    w_next_dx   = r_dx;
    w_hit       = 1'b0;
    w_p1_scores = 1'b0;
    w_p2_scores = 1'b0;

    if (w_ny < 0) begin
      w_next_y  = 9'd0;
      w_next_dy = 1'b1;
    end else if (w_ny + L_BS > L_SH) begin
      w_next_y  = L_Y_MAX[8:0];
      w_next_dy = 1'b0;
    end

    // A hit needs the ball to cross the paddle face this frame; once it is
    // past the face it can only travel on to the wall.
    if (!r_dx) begin
      if ((w_x_s >= L_P1_FACE) && (w_nx < L_P1_FACE) && w_ov1) begin
        w_next_x  = L_P1_FACE[9:0];
        w_next_dx = 1'b1;
        w_hit     = 1'b1;
      end else if (w_nx < 0) begin
        w_p2_scores = 1'b1;
      end
    end else begin
      if ((w_x_s + L_BS <= L_P2_FACE) && (w_nx + L_BS > L_P2_FACE) && w_ov2) begin
        w_next_x  = L_P2_STOP[9:0];
        w_next_dx = 1'b0;
        w_hit     = 1'b1;
      end else if (w_nx + L_BS > L_SW) begin
        w_p1_scores = 1'b1;
      end
    end
  end

  assign w_p1_inc      = r_p1_score + 4'd1;
  assign w_p2_inc      = r_p2_score + 4'd1;
  assign w_win         = w_p1_scores ? (w_p1_inc == L_WIN) : (w_p2_inc == L_WIN);
  assign w_tick_play   = (r_state == ST_PLAY) && frame_tick;
  assign w_enter_serve = ((r_state == ST_IDLE) && start) ||
                         (w_tick_play && (w_p1_scores || w_p2_scores) && !w_win);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ball_x   <= L_CX;
      r_ball_y   <= L_CY;
      r_p1_score <= 4'd0;
      r_p2_score <= 4'd0;
      r_p1_point <= 1'b0;
      r_p2_point <= 1'b0;
      r_dx       <= 1'b1;
      r_dy       <= 1'b1;
      r_cnt      <= '0;
    end else begin
      r_p1_point <= 1'b0;
      r_p2_point <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_SERVE;
            r_cnt   <= '0;
          end
        end
        ST_SERVE: begin
          if (frame_tick) begin
            if (r_cnt == L_CNT_LAST) begin
              r_state <= ST_PLAY;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_PLAY: begin
          if (frame_tick) begin
            if (w_p1_scores || w_p2_scores) begin
              r_ball_x <= L_CX;
              r_ball_y <= L_CY;
              r_cnt    <= '0;
              // Serve toward whoever just conceded.
              r_dx     <= w_p1_scores;
              if (w_p1_scores) begin
                r_p1_score <= w_p1_inc;
                r_p1_point <= 1'b1;
              end else begin
                r_p2_score <= w_p2_inc;
                r_p2_point <= 1'b1;
              end
              r_state <= w_win ? ST_DONE : ST_SERVE;
            end else begin
              r_ball_x <= w_next_x;
              r_ball_y <= w_next_y;
              r_dx     <= w_next_dx;
              r_dy     <= w_next_dy;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_DONE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ball_x   = r_ball_x;
  assign ball_y   = r_ball_y;
  assign p1_score = r_p1_score;
  assign p2_score = r_p2_score;
  assign p1_point = r_p1_point;
  assign p2_point = r_p2_point;
  assign state    = r_state;

endmodule

// File: tb/tb_ball_engine.sv
// Self-checking bench for ball_engine: randomized paddles/ticks checked
// against an integer game model kept in the bench.
module tb_ball_engine;

  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int BALL_SIZE    = 10;
  localparam int PADDLE_W     = 10;
  localparam int PADDLE_H     = 50;
  localparam int P1_X         = 0;
  localparam int P2_X         = 630;
  localparam int SPEED_X      = 2;
  localparam int SPEED_Y      = 2;
  localparam int SERVE_FRAMES = 60;
  localparam int WIN_SCORE    = 10;
  localparam int MAX_SPEED_X  = 8;
`ifdef SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       frame_tick;
  logic       start;
  logic [8:0] p1_y;
  logic [8:0] p2_y;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic       p1_point;
  logic       p2_point;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  // Game model: plain integers, directions as +1/-1.
  int m_state, m_x, m_y, m_dx, m_dy, m_s1, m_s2, m_pt1, m_pt2, m_cnt, m_spd;
  int m_hits, m_points;

  ball_engine dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .start      (start),
    .p1_y       (p1_y),
    .p2_y       (p2_y),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .p1_score   (p1_score),
    .p2_score   (p2_score),
    .p1_point   (p1_point),
    .p2_point   (p2_point),
    .state      (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [30:0] obs_vec();
    return {ball_x, ball_y, p1_score, p2_score, p1_point, p2_point, state};
  endfunction

  function automatic logic [30:0] exp_vec();
    return {10'(m_x), 9'(m_y), 4'(m_s1), 4'(m_s2), m_pt1[0], m_pt2[0], 2'(m_state)};
  endfunction

  function automatic string got_str();
    return $sformatf("got x=%0d y=%0d s=%0d/%0d pt=%0b%0b st=%0d",
                     ball_x, ball_y, p1_score, p2_score, p1_point, p2_point, state);
  endfunction

  function automatic string want_str();
    return $sformatf("want x=%0d y=%0d s=%0d/%0d pt=%0d%0d st=%0d",
                     m_x, m_y, m_s1, m_s2, m_pt1, m_pt2, m_state);
  endfunction

  function automatic int track(input int y);
    int p;
    p = y - 20;
    if (p < 0) p = 0;
    if (p > SCREEN_H - PADDLE_H) p = SCREEN_H - PADDLE_H;
    return p;
  endfunction

  function automatic int avoid(input int y);
    return (y < 240) ? (SCREEN_H - PADDLE_H) : 0;
  endfunction

  task automatic model_point(input int who);
    bit win;
    if (who == 1) begin
      m_s1++; m_pt1 = 1; m_dx = 1; win = (m_s1 == WIN_SCORE);
    end else begin
      m_s2++; m_pt2 = 1; m_dx = -1; win = (m_s2 == WIN_SCORE);
    end
    m_x = (SCREEN_W - BALL_SIZE) / 2;
    m_y = (SCREEN_H - BALL_SIZE) / 2;
    m_state = win ? 3 : 1;
    m_cnt = 0;
    m_spd = SPEED_X;
    m_points++;
  endtask

  task automatic model_play(input int p1, input int p2);
    int nx, ny, ndy;
    bit ov1, ov2, hit;
    nx  = m_x + m_dx * m_spd;
    ny  = m_y + m_dy * SPEED_Y;
    ndy = m_dy;
    hit = 0;
    ov1 = (m_y + BALL_SIZE > p1) && (m_y < p1 + PADDLE_H);
    ov2 = (m_y + BALL_SIZE > p2) && (m_y < p2 + PADDLE_H);
    if (ny < 0) begin
      ny = 0; ndy = 1;
    end else if (ny + BALL_SIZE > SCREEN_H) begin
      ny = SCREEN_H - BALL_SIZE; ndy = -1;
    end
    if (m_dx < 0) begin
      if (m_x >= P1_X + PADDLE_W && nx < P1_X + PADDLE_W && ov1) begin
        nx = P1_X + PADDLE_W; m_dx = 1; hit = 1;
      end else if (nx < 0) begin
        model_point(2);
        return;
      end
    end else begin
      if (m_x + BALL_SIZE <= P2_X && nx + BALL_SIZE > P2_X && ov2) begin
        nx = P2_X - BALL_SIZE; m_dx = -1; hit = 1;
      end else if (nx + BALL_SIZE > SCREEN_W) begin
        model_point(1);
        return;
      end
    end
    m_x = nx;
    m_y = ny;
    m_dy = ndy;
    if (hit) begin
      m_hits++;
      if (SPEEDUP && m_spd < MAX_SPEED_X) m_spd++;
    end
  endtask

  task automatic model_apply(input bit tick, input bit st, input bit rst, input int p1, input int p2);
    if (rst) begin
      m_state = 0; m_x = (SCREEN_W - BALL_SIZE) / 2; m_y = (SCREEN_H - BALL_SIZE) / 2;
      m_s1 = 0; m_s2 = 0; m_pt1 = 0; m_pt2 = 0; m_dx = 1; m_dy = 1; m_cnt = 0;
      m_spd = SPEED_X;
      return;
    end
    m_pt1 = 0;
    m_pt2 = 0;
    case (m_state)
      0: if (st) begin m_state = 1; m_cnt = 0; m_spd = SPEED_X; end
      1: if (tick) begin
           if (m_cnt == SERVE_FRAMES - 1) m_state = 2;
           else m_cnt++;
         end
      2: if (tick) model_play(p1, p2);
      default: ;
    endcase
  endtask

  // Drive one clock cycle of inputs and advance the model alongside the DUT.
  task automatic step(input bit tick, input bit st, input bit rst, input int p1, input int p2);
    frame_tick = tick; start = st; reset = rst;
    p1_y = 9'(p1); p2_y = 9'(p2);
    @(posedge clk);
    model_apply(tick, st, rst, p1, p2);
    #1;
    frame_tick = 1'b0; start = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    total++;
    if (obs_vec() !== {10'd315, 9'd235, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00}) begin
      bad++; $display("FAIL reset_values: %s want x=315 y=235 s=0/0 pt=00 st=0", got_str());
    end
    $display("reset: %s", got_str());
  endtask

  task automatic test_serve();
    step(0, 1, 0, 100, 100);
    total++;
    if (state !== 2'b01) begin
      bad++; $display("FAIL start_to_serve: got st=%0d want st=1", state);
    end
    for (int i = 1; i <= SERVE_FRAMES; i++) begin
      step(1, 0, 0, $urandom_range(0, 430), $urandom_range(0, 430));
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL serve_tick%0d: %s %s", i, got_str(), want_str());
      end
    end
    total++;
    if (state !== 2'b10 || ball_x !== 10'd315 || ball_y !== 9'd235) begin
      bad++; $display("FAIL serve_to_play: %s want x=315 y=235 st=2", got_str());
    end
    step(1, 0, 0, 100, 100);
    total++;
    if (ball_x !== 10'd317 || ball_y !== 9'd237) begin
      bad++; $display("FAIL first_move: %s want x=317 y=237", got_str());
    end
    $display("serve: play started, first move %s", got_str());
  endtask

  task automatic test_paddle_hit();
    int budget;
    budget = 20000;
    m_hits = 0;
    while (m_hits < 3 && budget > 0) begin
      step(1, 1'($urandom), 0, track(m_y), track(m_y));
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL paddle_hit: %s %s", got_str(), want_str());
      end
      if ($urandom_range(0, 2) == 0) begin
        step(0, 1'($urandom), 0, $urandom_range(0, 430), $urandom_range(0, 430));
        total++;
        if (obs_vec() !== exp_vec()) begin
          bad++; $display("FAIL paddle_idle: %s %s", got_str(), want_str());
        end
      end
      budget--;
    end
    total++;
    if (budget == 0) begin
      bad++; $display("FAIL paddle_hit_timeout: got hits=%0d want 3", m_hits);
    end
    $display("paddle_hit: hits=%0d speed=%0d %s", m_hits, m_spd, got_str());
  endtask

  task automatic test_miss();
    int budget, pts;
    budget = 20000;
    pts = m_points;
    while (m_points == pts && budget > 0) begin
      step(1, 0, 0, track(m_y), avoid(m_y));
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL miss_run: %s %s", got_str(), want_str());
      end
      budget--;
    end
    total++;
    if (budget == 0 || p1_point !== 1'b1 || p2_point !== 1'b0 || ball_x !== 10'd315 ||
        ball_y !== 9'd235 || state !== 2'b01) begin
      bad++; $display("FAIL miss_score: %s want p1 point, x=315 y=235 st=1", got_str());
    end
    step(0, 0, 0, 0, 0);
    total++;
    if (p1_point !== 1'b0 || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL point_pulse_width: %s %s", got_str(), want_str());
    end
    $display("miss: p1 scored, %s", got_str());
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom), ($urandom_range(0, 15) == 0), 0,
           $urandom_range(0, 430), $urandom_range(0, 430));
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL random_cyc%0d: %s %s", i, got_str(), want_str());
      end
      if (m_pt1 != 0 || m_pt2 != 0) $display("random: point, %s", got_str());
    end
  endtask

  task automatic test_win();
    int budget;
    budget = 20000;
    while (m_state != 3 && budget > 0) begin
      step(1, (m_state == 0), 0, track(m_y), avoid(m_y));
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL win_run: %s %s", got_str(), want_str());
      end
      if (m_pt1 != 0 || m_pt2 != 0) $display("win: point, %s", got_str());
      budget--;
    end
    total++;
    if (budget == 0 || state !== 2'b11 || (p1_score !== 4'd10 && p2_score !== 4'd10)) begin
      bad++; $display("FAIL win_done: %s want st=3 and a score of 10", got_str());
    end
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom), 1'($urandom), 0, $urandom_range(0, 430), $urandom_range(0, 430));
      total++;
      if (obs_vec() !== exp_vec() || ball_x !== 10'd315 || p1_point !== 1'b0) begin
        bad++; $display("FAIL done_frozen: %s %s", got_str(), want_str());
      end
    end
    step(0, 0, 1, 0, 0);
    total++;
    if (obs_vec() !== {10'd315, 9'd235, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00}) begin
      bad++; $display("FAIL done_reset: %s want x=315 y=235 s=0/0 st=0", got_str());
    end
    $display("win: game over then reset, %s", got_str());
  endtask

  task automatic test_reset_tick();
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < SERVE_FRAMES + 300; i++) begin
      step(1, 0, 0, avoid(m_y), avoid(m_y));
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL pre_reset_play: %s %s", got_str(), want_str());
      end
      if (m_state == 2 && m_x > 600) break;
    end
    step(1, 1, 1, avoid(m_y), avoid(m_y));
    total++;
    if (obs_vec() !== {10'd315, 9'd235, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00}) begin
      bad++; $display("FAIL reset_with_tick: %s want x=315 y=235 s=0/0 pt=00 st=0", got_str());
    end
    $display("reset_tick: %s", got_str());
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; start = 1'b0; p1_y = '0; p2_y = '0;
    m_hits = 0; m_points = 0;
    test_reset();
    test_serve();
    test_paddle_hit();
    test_miss();
    test_random();
    test_win();
    test_reset_tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
